// File: rtl/fxp_out_sat_if.sv
// fxp_out_sat_if
//   Streaming handshake bundle for the fixed-point output stage.
//   Input side : in_valid, in_ready, in_data (signed product), in_ovf
//   Output side: out_valid, out_ready, out_data (saturated), out_sat
//   Modports:
//     master - the environment (drives input channel, accepts output channel)
//     slave  - the stage itself
interface fxp_out_sat_if #(
  parameter int IN_W  = 64,
  parameter int OUT_W = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic             in_ovf;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_sat;

  modport master (
    output in_valid, in_data, in_ovf, out_ready,
    input  in_ready, out_valid, out_data, out_sat
  );

  modport slave (
    input  in_valid, in_data, in_ovf, out_ready,
    output in_ready, out_valid, out_data, out_sat
  );
endinterface

// File: rtl/fxp_out_sat.sv
// fxp_out_sat
//   Two-stage output stage for the IIR multiplier datapath. Stage S1 drops
//   FRAC_SHIFT fractional bits by an arithmetic right shift (optionally
//   rounding half toward +inf); stage S2 saturates to the signed OUT_W range.
//   Both stages advance together whenever the output register is empty or
//   being accepted, so in_ready is a combinational function of out_ready.
//   Saturated outputs that are accepted downstream are tallied in a sticky
//   flag and a non-wrapping counter.
//
//   Build option:
//     FXP_OUT_SAT_ROUND_EN - defined: add 2^(FRAC_SHIFT-1) before the shift
//                            (round half up); undefined: plain truncation
//                            toward -inf with no adder.
//
//   Ports:
//     clk        rising-edge clock
//     rst        synchronous active-high reset
//     bus        fxp_out_sat_if.slave (input and output handshake channels)
//     clr_stats  synchronous clear of sat_sticky/sat_count (wins over a count)
//     sat_sticky set by any accepted saturated output
//     sat_count  number of accepted saturated outputs, holds at all-ones
module fxp_out_sat #(
  parameter int IN_W       = 64,
  parameter int OUT_W      = 32,
  parameter int FRAC_SHIFT = 16,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  fxp_out_sat_if.slave     bus,
  input  logic             clr_stats,
  output logic             sat_sticky,
  output logic [CNT_W-1:0] sat_count
);

  // One guard bit above the product so the rounding add can never wrap.
  localparam int EXT_W = IN_W + 1;
  // Bits [EXT_W-1:OUT_W-1] of the shifted value must all match the sign bit
  // for the value to fit in OUT_W signed bits.
  localparam int CHK_W = EXT_W - OUT_W + 1;

  localparam logic [OUT_W-1:0] SAT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] SAT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  // ---------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------
  logic adv;

  logic             s1_valid_reg;
  logic [EXT_W-1:0] s1_sh_reg;
  logic             s1_force_reg;
  logic             s1_sgn_reg;

  logic             s2_valid_reg;
  logic [OUT_W-1:0] s2_data_reg;
  logic             s2_sat_reg;

  logic             sticky_reg;
  logic [CNT_W-1:0] count_reg;

  assign adv          = !s2_valid_reg || bus.out_ready;
  assign bus.in_ready = adv;

  assign bus.out_valid = s2_valid_reg;
  assign bus.out_data  = s2_data_reg;
  assign bus.out_sat   = s2_sat_reg;

  assign sat_sticky = sticky_reg;
  assign sat_count  = count_reg;

  // ---------------------------------------------------------------------
  // S1 combinational: sign extend, optional round, arithmetic shift
  // ---------------------------------------------------------------------
  logic signed [EXT_W-1:0] ext;
  logic signed [EXT_W-1:0] sum;
  logic signed [EXT_W-1:0] s1_sh_next;

  assign ext = {bus.in_data[IN_W-1], bus.in_data};

`ifdef FXP_OUT_SAT_ROUND_EN
  localparam logic [EXT_W-1:0] RND = {{(EXT_W-1){1'b0}}, 1'b1} << (FRAC_SHIFT - 1);
  assign sum = ext + $signed(RND);
`else
  assign sum = ext;
`endif

  assign s1_sh_next = sum >>> FRAC_SHIFT;

  // ---------------------------------------------------------------------
  // S2 combinational: range check against the OUT_W signed range
  // ---------------------------------------------------------------------
  logic [CHK_W-1:0] agree;
  logic             in_range;
  logic [OUT_W-1:0] s2_data_next;
  logic             s2_sat_next;

  genvar gi;
  generate
    for (gi = 0; gi < CHK_W; gi++) begin : g_agree
      assign agree[gi] = (s1_sh_reg[OUT_W-1+gi] == s1_sh_reg[EXT_W-1]);
    end
  endgenerate

  assign in_range = &agree;

  always_comb begin
    s2_data_next = s1_sh_reg[OUT_W-1:0];
    s2_sat_next  = 1'b0;
    if (s1_force_reg) begin
      // Upstream already overflowed: the product bits are meaningless, so
      // saturate in the direction of the product's sign.
      s2_sat_next  = 1'b1;
      s2_data_next = s1_sgn_reg ? SAT_MIN : SAT_MAX;
    end else if (!in_range) begin
      s2_sat_next  = 1'b1;
      s2_data_next = s1_sh_reg[EXT_W-1] ? SAT_MIN : SAT_MAX;
    end
  end

  // ---------------------------------------------------------------------
  // Pipeline registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      s1_sh_reg    <= '0;
      s1_force_reg <= 1'b0;
      s1_sgn_reg   <= 1'b0;
      s2_valid_reg <= 1'b0;
      s2_data_reg  <= '0;
      s2_sat_reg   <= 1'b0;
    end else if (adv) begin
      s1_valid_reg <= bus.in_valid;
      s2_valid_reg <= s1_valid_reg;
      // Payload only moves with a valid sample; bubbles leave it untouched.
      if (bus.in_valid) begin
        s1_sh_reg    <= s1_sh_next;
        s1_force_reg <= bus.in_ovf;
        s1_sgn_reg   <= bus.in_data[IN_W-1];
      end
      if (s1_valid_reg) begin
        s2_data_reg <= s2_data_next;
        s2_sat_reg  <= s2_sat_next;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Saturation statistics, updated only on accepted outputs
  // ---------------------------------------------------------------------
  logic             acc;
  logic             sticky_next;
  logic [CNT_W-1:0] count_next;

  assign acc = s2_valid_reg && bus.out_ready && s2_sat_reg;

  always_comb begin
    sticky_next = sticky_reg;
    count_next  = count_reg;
    if (clr_stats) begin
      sticky_next = 1'b0;
      count_next  = '0;
    end else if (acc) begin
      sticky_next = 1'b1;
      if (count_reg != {CNT_W{1'b1}}) begin
        count_next = count_reg + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_reg <= 1'b0;
      count_reg  <= '0;
    end else begin
      sticky_reg <= sticky_next;
      count_reg  <= count_next;
    end
  end

endmodule

// File: tb/tb_fxp_out_sat.sv
// tb_fxp_out_sat
//   Self-checking bench for fxp_out_sat at default parameters. A table of
//   directed vectors checks values and the two-cycle latency; hand-written
//   sequences cover statistics clear, backpressure, mid-run reset and the
//   counter ceiling; a random stream is compared against an arithmetic
//   reference model through a scoreboard queue.
module tb_fxp_out_sat;
  localparam int IN_W       = 64;
  localparam int OUT_W      = 32;
  localparam int FRAC_SHIFT = 16;
  localparam int CNT_W      = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             clr_stats = 1'b0;
  logic             sat_sticky;
  logic [CNT_W-1:0] sat_count;

  always #5 clk = ~clk;

  fxp_out_sat_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

  fxp_out_sat #(
    .IN_W(IN_W), .OUT_W(OUT_W), .FRAC_SHIFT(FRAC_SHIFT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .clr_stats(clr_stats),
    .sat_sticky(sat_sticky),
    .sat_count(sat_count)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // Reference: floor((x + r) / 2^FRAC_SHIFT) with wide integer arithmetic,
  // then clamp to the signed OUT_W range.
  function automatic void ref_calc(input logic [IN_W-1:0] d, input logic ovf,
                                   output logic [OUT_W-1:0] q, output logic s);
    logic signed [127:0] v, den, hi, lo;
    v   = {{(128-IN_W){d[IN_W-1]}}, d};
    den = 128'sd1 <<< FRAC_SHIFT;
`ifdef FXP_OUT_SAT_ROUND_EN
    v = v + den / 128'sd2;
`endif
    if (v >= 0) v = v / den;
    else        v = -((-v + den - 128'sd1) / den);
    hi = (128'sd1 <<< (OUT_W - 1)) - 128'sd1;
    lo = -(128'sd1 <<< (OUT_W - 1));
    if (ovf) begin
      s = 1'b1;
      q = d[IN_W-1] ? lo[OUT_W-1:0] : hi[OUT_W-1:0];
    end else if (v > hi) begin
      s = 1'b1; q = hi[OUT_W-1:0];
    end else if (v < lo) begin
      s = 1'b1; q = lo[OUT_W-1:0];
    end else begin
      s = 1'b0; q = v[OUT_W-1:0];
    end
  endfunction

  // -------------------------------------------------------------------
  // Scoreboard monitor, samples on the falling edge
  // -------------------------------------------------------------------
  typedef struct packed {
    logic [OUT_W-1:0] data;
    logic             sat;
  } exp_t;

  exp_t             exp_q[$];
  exp_t             m_e;
  int unsigned      m_cnt = 0;
  logic             m_sticky = 1'b0;
  logic             prev_stall = 1'b0;
  logic [OUT_W-1:0] prev_data;
  logic             prev_sat;
  logic             out_x;
  logic             x_sat;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      m_cnt      = 0;
      m_sticky   = 1'b0;
      prev_stall = 1'b0;
    end else begin
      chk("sat_count", 64'(sat_count), 64'(m_cnt));
      chk("sat_sticky", 64'(sat_sticky), 64'(m_sticky));
      if (prev_stall) begin
        chk("stall_valid", 64'(bus.out_valid), 64'(1));
        chk("stall_data", 64'(bus.out_data), 64'(prev_data));
        chk("stall_sat", 64'(bus.out_sat), 64'(prev_sat));
      end
      chk("in_ready", 64'(bus.in_ready), 64'(!(bus.out_valid && !bus.out_ready)));
      out_x = bus.out_valid && bus.out_ready;
      x_sat = 1'b0;
      if (bus.out_valid && exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_output: got out_valid data=0x%0h want no output", bus.out_data);
      end else if (out_x) begin
        m_e = exp_q.pop_front();
        chk("out_data", 64'(bus.out_data), 64'(m_e.data));
        chk("out_sat", 64'(bus.out_sat), 64'(m_e.sat));
        x_sat = m_e.sat;
      end
      if (clr_stats) begin
        m_cnt    = 0;
        m_sticky = 1'b0;
      end else if (out_x && x_sat) begin
        m_sticky = 1'b1;
        if (m_cnt < (2**CNT_W) - 1) m_cnt++;
      end
      if (bus.in_valid && bus.in_ready) begin
        ref_calc(bus.in_data, bus.in_ovf, m_e.data, m_e.sat);
        exp_q.push_back(m_e);
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
      prev_sat   = bus.out_sat;
    end
  end

  // -------------------------------------------------------------------
  // Directed vector table
  // -------------------------------------------------------------------
  typedef struct {
    string            name;
    logic [IN_W-1:0]  d;
    logic             ovf;
    logic [OUT_W-1:0] q;
    logic             s;
  } vec_t;

  localparam int NV = 12;
  vec_t tv[NV];

  task automatic set_vec(input int i, input string n, input logic [63:0] d,
                         input logic o, input logic [31:0] q, input logic s);
    tv[i].name = n; tv[i].d = d; tv[i].ovf = o; tv[i].q = q; tv[i].s = s;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0]      r;
    logic [OUT_W-1:0] got[$];
    int               sent;

    set_vec(0,  "basic_one",   64'h0000_0000_0001_0000, 1'b0, 32'h0000_0001, 1'b0);
    set_vec(1,  "pos_sat",     64'h0000_8000_0000_0000, 1'b0, 32'h7FFF_FFFF, 1'b1);
    set_vec(2,  "neg_min_ok",  64'hFFFF_8000_0000_0000, 1'b0, 32'h8000_0000, 1'b0);
    set_vec(3,  "neg_sat",     64'hFFFF_7FFF_FFFF_0000, 1'b0, 32'h8000_0000, 1'b1);
`ifdef FXP_OUT_SAT_ROUND_EN
    set_vec(4,  "rnd_half_p",  64'h0000_0000_0000_8000, 1'b0, 32'h0000_0001, 1'b0);
    set_vec(5,  "rnd_half_n",  64'hFFFF_FFFF_FFFF_8000, 1'b0, 32'h0000_0000, 1'b0);
    set_vec(11, "rnd_into_sat",64'h0000_7FFF_FFFF_8000, 1'b0, 32'h7FFF_FFFF, 1'b1);
`else
    set_vec(4,  "rnd_half_p",  64'h0000_0000_0000_8000, 1'b0, 32'h0000_0000, 1'b0);
    set_vec(5,  "rnd_half_n",  64'hFFFF_FFFF_FFFF_8000, 1'b0, 32'hFFFF_FFFF, 1'b0);
    set_vec(11, "rnd_into_sat",64'h0000_7FFF_FFFF_8000, 1'b0, 32'h7FFF_FFFF, 1'b0);
`endif
    set_vec(6,  "ovf_pos",     64'h0000_0000_0001_0000, 1'b1, 32'h7FFF_FFFF, 1'b1);
    set_vec(7,  "ovf_neg",     64'hFFFF_FFFF_FFFF_0000, 1'b1, 32'h8000_0000, 1'b1);
    set_vec(8,  "in_max",      64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 32'h7FFF_FFFF, 1'b1);
    set_vec(9,  "in_min",      64'h8000_0000_0000_0000, 1'b0, 32'h8000_0000, 1'b1);
    set_vec(10, "pos_max_ok",  64'h0000_7FFF_FFFF_0000, 1'b0, 32'h7FFF_FFFF, 1'b0);

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_ovf    = 1'b0;
    bus.out_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_out_data", 64'(bus.out_data), 64'(0));
    chk("rst_out_sat", 64'(bus.out_sat), 64'(0));
    chk("rst_sticky", 64'(sat_sticky), 64'(0));
    chk("rst_count", 64'(sat_count), 64'(0));
    chk("rst_in_ready", 64'(bus.in_ready), 64'(1));

    // Table: one sample at a time, value plus exact two-cycle latency
    for (int i = 0; i < NV; i++) begin
      @(posedge clk); #1;
      bus.in_valid = 1'b1;
      bus.in_data  = tv[i].d;
      bus.in_ovf   = tv[i].ovf;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.in_ovf   = 1'b0;
      @(negedge clk);
      chk({tv[i].name, "_lat1_valid"}, 64'(bus.out_valid), 64'(0));
      @(negedge clk);
      chk({tv[i].name, "_lat2_valid"}, 64'(bus.out_valid), 64'(1));
      chk({tv[i].name, "_data"}, 64'(bus.out_data), 64'(tv[i].q));
      chk({tv[i].name, "_sat"}, 64'(bus.out_sat), 64'(tv[i].s));
      $display("vec %s in=0x%h ovf=%0d out=0x%h sat=%0d", tv[i].name, tv[i].d,
               tv[i].ovf, bus.out_data, bus.out_sat);
    end

    // Clear in the same cycle as an accepted saturated transfer
    @(negedge clk);
    chk("pre_clr_count_nonzero", 64'(sat_count != '0), 64'(1));
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.in_data = 64'h0000_0000_0001_0000; bus.in_ovf = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.in_ovf = 1'b0;
    @(posedge clk); #1;
    clr_stats = 1'b1;
    @(negedge clk);
    chk("clr_xfer_valid", 64'(bus.out_valid), 64'(1));
    chk("clr_xfer_sat", 64'(bus.out_sat), 64'(1));
    @(posedge clk); #1;
    clr_stats = 1'b0;
    @(negedge clk);
    chk("clr_count", 64'(sat_count), 64'(0));
    chk("clr_sticky", 64'(sat_sticky), 64'(0));
    $display("seq clr_stats count=%0d sticky=%0d", sat_count, sat_sticky);

    // Single positive saturation after a clear counts exactly once
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.in_data = 64'h0000_8000_0000_0000;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("pos_sat_count", 64'(sat_count), 64'(1));
    chk("pos_sat_sticky", 64'(sat_sticky), 64'(1));
    $display("seq pos_sat count=%0d sticky=%0d", sat_count, sat_sticky);

    // Backpressure: six samples, out_ready low for cycles 3..5
    sent = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      bus.out_ready = !(c >= 3 && c <= 5);
      bus.in_valid  = (sent < 6);
      bus.in_data   = 64'(sent + 1) << 16;
      bus.in_ovf    = 1'b0;
      @(negedge clk);
      if (c >= 3 && c <= 5) chk("bp_in_ready_low", 64'(bus.in_ready), 64'(0));
      if (bus.out_valid && bus.out_ready) begin
        got.push_back(bus.out_data);
        $display("bp out=0x%h", bus.out_data);
      end
      if (bus.in_valid && bus.in_ready) sent++;
    end
    bus.in_valid = 1'b0;
    chk("bp_out_count", 64'(got.size()), 64'(6));
    for (int k = 0; k < got.size(); k++) chk("bp_order", 64'(got[k]), 64'(k + 1));

    // Reset with samples in flight: nothing may come out afterwards
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.in_data = 64'h0000_0000_0003_0000;
    @(posedge clk); #1;
    bus.in_data = 64'h0000_0000_0004_0000;
    @(posedge clk); #1;
    rst = 1'b1; bus.in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("post_rst_out_valid", 64'(bus.out_valid), 64'(0));
    end
    $display("seq mid_reset out_valid=%0d", bus.out_valid);

    // Random stream against the reference model
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.in_ovf    = ($urandom_range(0, 15) == 0);
      clr_stats     = ($urandom_range(0, 63) == 0);
      r = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0: bus.in_data = r;
        1: bus.in_data = {{24{r[39]}}, r[39:0]};
        2: bus.in_data = 64'h0000_8000_0000_0000 + 64'($urandom_range(0, 262143)) - 64'd131072;
        default: bus.in_data = 64'hFFFF_8000_0000_0000 + 64'($urandom_range(0, 262143)) - 64'd131072;
      endcase
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.in_ovf = 1'b0; bus.out_ready = 1'b1; clr_stats = 1'b0;
    repeat (4) @(negedge clk);
    chk("rand_drain", 64'(exp_q.size()), 64'(0));

    // Counter ceiling: more saturated transfers than the counter can hold
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.in_ovf = 1'b1; bus.in_data = 64'h0000_0000_0005_0000;
    repeat (65540) @(posedge clk);
    #1 bus.in_valid = 1'b0; bus.in_ovf = 1'b0;
    repeat (4) @(negedge clk);
    chk("count_ceiling", 64'(sat_count), 64'(16'hFFFF));
    chk("ceiling_sticky", 64'(sat_sticky), 64'(1));
    chk("final_drain", 64'(exp_q.size()), 64'(0));
    $display("seq ceiling count=0x%h", sat_count);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
